whiz_graphics: RTL and testbench



---
 rtl/whiz_graphics.sv | 234 +++++++++++++++++++++++
 tb/tb_whiz_graphics.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/whiz_graphics.sv
// Background-only LCD controller: VRAM/OAM/register peripheral, 456x154 dot timing, BGP-shaded pixels.
// Bus reads return one cycle after re; pixel x is registered one cycle after dot 80+x; no backpressure.
module whiz_graphics #(
  parameter int DEBUG_OUT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic [1:0]  pix,
  output logic        pix_valid,
  output logic        hblank,
  output logic        vblank,
  output logic        irq_vblank,
  output logic        irq_stat
);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_DRAW   = 2'd3;

  logic unused_debug;
  assign unused_debug = (DEBUG_OUT != 0);

  logic [7:0] vram [8192];
  logic [7:0] oam  [160];

  logic [7:0] lcdc_q, lcdc_d, scy_q, scy_d, scx_q, scx_d, lyc_q, lyc_d;
  logic [7:0] bgp_q, bgp_d, obp0_q, obp0_d, obp1_q, obp1_d, wy_q, wy_d, wx_q, wx_d;
  logic [3:0] stat_en_q, stat_en_d;
  logic [7:0] ly_q, ly_d;
  logic [8:0] dot_q, dot_d;
  logic       lyc_flag_q, lyc_flag_d;
  logic       stat_line_q, stat_line_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] pix_q, pix_d;
  logic       pix_valid_q, pix_valid_d;
  logic       irq_vblank_q, irq_vblank_d;
  logic       irq_stat_q, irq_stat_d;

  logic       sel_vram, sel_oam, sel_reg;
  logic       vram_wr, oam_wr, reg_wr;
  logic [1:0] mode_cur, mode_nxt;

  function automatic logic [1:0] mode_of(input logic on, input logic [7:0] ly, input logic [8:0] dot);
    logic [1:0] m;
    if (!on)                m = MODE_HBLANK;
    else if (ly >= 8'd144)  m = MODE_VBLANK;
    else if (dot < 9'd80)   m = MODE_OAM;
    else if (dot < 9'd252)  m = MODE_DRAW;
    else                    m = MODE_HBLANK;
    return m;
  endfunction

  assign sel_vram = (addr[15:13] == 3'b100);
  assign sel_oam  = (addr[15:8] == 8'hFE) && (addr[7:0] < 8'hA0);
  assign sel_reg  = (addr[15:4] == 12'hFF4) && (addr[3:0] <= 4'hB);
  assign hit      = sel_vram | sel_oam | sel_reg;

  assign mode_cur = mode_of(lcdc_q[7], ly_q, dot_q);

  // The PPU owns VRAM while drawing and OAM during both OAM scan and drawing.
  assign vram_wr = we && sel_vram && (mode_cur != MODE_DRAW);
  assign oam_wr  = we && sel_oam && !mode_cur[1];
  assign reg_wr  = we && sel_reg;

  always_comb begin
    lcdc_d    = lcdc_q;
    stat_en_d = stat_en_q;
    scy_d     = scy_q;
    scx_d     = scx_q;
    lyc_d     = lyc_q;
    bgp_d     = bgp_q;
    obp0_d    = obp0_q;
    obp1_d    = obp1_q;
    wy_d      = wy_q;
    wx_d      = wx_q;
    if (reg_wr) begin
      case (addr[3:0])
        4'h0:    lcdc_d    = wdata;
        4'h1:    stat_en_d = wdata[6:3];
        4'h2:    scy_d     = wdata;
        4'h3:    scx_d     = wdata;
        4'h5:    lyc_d     = wdata;
        4'h7:    bgp_d     = wdata;
        4'h8:    obp0_d    = wdata;
        4'h9:    obp1_d    = wdata;
        4'hA:    wy_d      = wdata;
        4'hB:    wx_d      = wdata;
        default: ;
      endcase
    end
  end

  // Counters stay parked at 0 while off and on the edge the LCD is switched on.
  always_comb begin
    dot_d = 9'd0;
    ly_d  = 8'd0;
    if (lcdc_q[7] && lcdc_d[7]) begin
      if (dot_q == 9'd455) begin
        dot_d = 9'd0;
        ly_d  = (ly_q == 8'd153) ? 8'd0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + 9'd1;
        ly_d  = ly_q;
      end
    end
  end

  always_comb begin
    mode_nxt     = mode_of(lcdc_d[7], ly_d, dot_d);
    lyc_flag_d   = (ly_d == lyc_d);
    stat_line_d  = lcdc_d[7] &&
                   ((lyc_flag_d && stat_en_d[3]) ||
                    ((mode_nxt == MODE_OAM)    && stat_en_d[2]) ||
                    ((mode_nxt == MODE_VBLANK) && stat_en_d[1]) ||
                    ((mode_nxt == MODE_HBLANK) && stat_en_d[0]));
    irq_stat_d   = stat_line_d && !stat_line_q;
    irq_vblank_d = lcdc_d[7] && (ly_d == 8'd144) && (dot_d == 9'd0);
  end

  logic       render;
  logic [7:0] px, by, bx, tile_idx, row_lo, row_hi;
  logic [12:0] map_addr, row_addr;
  logic [2:0] bsel;
  logic [1:0] colour;

  always_comb begin
    render   = lcdc_q[7] && (ly_q < 8'd144) && (dot_q >= 9'd80) && (dot_q < 9'd240);
    px       = dot_q[7:0] - 8'd80;
    by       = ly_q + scy_q;
    bx       = px + scx_q;
    map_addr = {2'b11, lcdc_q[3], by[7:3], bx[7:3]};
    tile_idx = vram[map_addr];
    // Signed tile mode: index 0 sits at 0x9000, indices 128-255 fold back to 0x8800.
    row_addr = {(lcdc_q[4] ? 1'b0 : ~tile_idx[7]), tile_idx, by[2:0], 1'b0};
    row_lo   = vram[row_addr];
    row_hi   = vram[{row_addr[12:1], 1'b1}];
    bsel     = 3'd7 - bx[2:0];
    colour   = lcdc_q[0] ? {row_hi[bsel], row_lo[bsel]} : 2'b00;
    pix_d       = render ? bgp_q[{colour, 1'b0} +: 2] : pix_q;
    pix_valid_d = render;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = 8'hFF;
      if (sel_vram) begin
        if (mode_cur != MODE_DRAW) rdata_d = vram[addr[12:0]];
      end else if (sel_oam) begin
        if (!mode_cur[1]) rdata_d = oam[addr[7:0]];
      end else if (sel_reg) begin
        case (addr[3:0])
          4'h0:    rdata_d = lcdc_q;
          4'h1:    rdata_d = {1'b1, stat_en_q, lyc_flag_q, mode_cur};
          4'h2:    rdata_d = scy_q;
          4'h3:    rdata_d = scx_q;
          4'h4:    rdata_d = ly_q;
          4'h5:    rdata_d = lyc_q;
          4'h7:    rdata_d = bgp_q;
          4'h8:    rdata_d = obp0_q;
          4'h9:    rdata_d = obp1_q;
          4'hA:    rdata_d = wy_q;
          4'hB:    rdata_d = wx_q;
          default: rdata_d = 8'hFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lcdc_q       <= 8'h91;
      stat_en_q    <= 4'h0;
      scy_q        <= 8'h00;
      scx_q        <= 8'h00;
      lyc_q        <= 8'h00;
      bgp_q        <= 8'hFC;
      obp0_q       <= 8'hFF;
      obp1_q       <= 8'hFF;
      wy_q         <= 8'h00;
      wx_q         <= 8'h00;
      ly_q         <= 8'd0;
      dot_q        <= 9'd0;
      lyc_flag_q   <= 1'b0;
      stat_line_q  <= 1'b0;
      rdata_q      <= 8'hFF;
      pix_q        <= 2'b00;
      pix_valid_q  <= 1'b0;
      irq_vblank_q <= 1'b0;
      irq_stat_q   <= 1'b0;
    end else begin
      lcdc_q       <= lcdc_d;
      stat_en_q    <= stat_en_d;
      scy_q        <= scy_d;
      scx_q        <= scx_d;
      lyc_q        <= lyc_d;
      bgp_q        <= bgp_d;
      obp0_q       <= obp0_d;
      obp1_q       <= obp1_d;
      wy_q         <= wy_d;
      wx_q         <= wx_d;
      ly_q         <= ly_d;
      dot_q        <= dot_d;
      lyc_flag_q   <= lyc_flag_d;
      stat_line_q  <= stat_line_d;
      rdata_q      <= rdata_d;
      pix_q        <= pix_d;
      pix_valid_q  <= pix_valid_d;
      irq_vblank_q <= irq_vblank_d;
      irq_stat_q   <= irq_stat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && vram_wr) vram[addr[12:0]] <= wdata;
    if (reset_n && oam_wr)  oam[addr[7:0]]   <= wdata;
  end

  assign rdata      = rdata_q;
  assign pix        = pix_q;
  assign pix_valid  = pix_valid_q;
  assign hblank     = lcdc_q[7] && (mode_cur == MODE_HBLANK);
  assign vblank     = (mode_cur == MODE_VBLANK);
  assign irq_vblank = irq_vblank_q;
  assign irq_stat   = irq_stat_q;

endmodule

// File: tb/tb_whiz_graphics.sv
// Directed bench for whiz_graphics: register table, one full frame of timing, and background pixel patterns.
module tb_whiz_graphics;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [7:0]  rdata;
  logic        hit;
  logic [1:0]  pix;
  logic        pix_valid, hblank, vblank, irq_vblank, irq_stat;

  whiz_graphics #(.DEBUG_OUT(0)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .hit(hit), .pix(pix), .pix_valid(pix_valid), .hblank(hblank),
    .vblank(vblank), .irq_vblank(irq_vblank), .irq_stat(irq_stat)
  );

  always #5 clk = ~clk;

  localparam int LINE    = 456;
  localparam int FRAME   = 456 * 154;
  localparam int MON_END = FRAME + LINE;

  int n_checks = 0;
  int n_fail   = 0;
  int now      = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] a;
    logic [7:0]  d;
    logic        hit;
    logic [7:0]  rd;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic run_to(input int t);
    while (now < t) tick();
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    check(name, rdata, exp);
  endtask

  task automatic set_rows(input logic [15:0] base, input logic [7:0] lo, input logic [7:0] hi);
    for (int r = 0; r < 8; r++) begin
      bus_wr(base + 16'(2 * r), lo);
      bus_wr(base + 16'(2 * r + 1), hi);
    end
  endtask

  // One visible line with every map entry pointing at tile 0 whose eight rows are {lo, hi}.
  task automatic pix_phase(input string nm, input logic [7:0] lcdc, input logic [7:0] scx,
                           input logic [7:0] bgp, input logic [7:0] lo, input logic [7:0] hi);
    int bad_v = 0;
    int bad_p = 0;
    int x, b, ci;
    logic [1:0] e;
    bus_wr(16'hFF43, scx);
    bus_wr(16'hFF47, bgp);
    bus_wr(16'hFF40, lcdc);
    for (int k = 0; k < 300; k++) begin
      if (k >= 81 && k <= 240) begin
        x  = k - 81;
        b  = 7 - ((x + int'(scx)) % 8);
        ci = lcdc[0] ? int'({hi[b], lo[b]}) : 0;
        e  = bgp[2 * ci +: 2];
        if (pix_valid !== 1'b1) bad_v++;
        if (pix !== e) bad_p++;
      end else if (pix_valid !== 1'b0) begin
        bad_v++;
      end
      tick();
    end
    bus_wr(16'hFF40, 8'h00);
    check({nm, "_valid_bad_cycles"}, bad_v, 0);
    check({nm, "_pix_bad_cycles"}, bad_p, 0);
  endtask

  // Per-cycle timing model for the first frame after the LCD is switched on.
  bit mon_en = 1'b0;
  int cyc = 0;
  int bad_vb = 0, bad_hb = 0, bad_iv = 0, bad_is = 0, bad_pv = 0;
  always @(negedge clk) begin : mon
    int line, dot;
    if (mon_en && cyc < MON_END) begin
      line = (cyc / LINE) % 154;
      dot  = cyc % LINE;
      if (vblank     !== (line >= 144))                          bad_vb++;
      if (hblank     !== (line < 144 && dot >= 252))             bad_hb++;
      if (irq_vblank !== (line == 144 && dot == 0))              bad_iv++;
      if (irq_stat   !== (cyc == 5 * LINE))                      bad_is++;
      if (pix_valid  !== (line < 144 && dot >= 81 && dot <= 240)) bad_pv++;
      cyc++;
    end
  end

  initial begin
    tbl.push_back('{1'b0, 1'b1, 16'hFF40, 8'h00, 1'b1, 8'h91});
    tbl.push_back('{1'b0, 1'b1, 16'hFF44, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'hFF47, 8'h00, 1'b1, 8'hFC});
    tbl.push_back('{1'b0, 1'b1, 16'h1234, 8'h00, 1'b0, 8'hFF});
    tbl.push_back('{1'b0, 1'b1, 16'hFF46, 8'h00, 1'b1, 8'hFF});
    tbl.push_back('{1'b0, 1'b1, 16'hFF4C, 8'h00, 1'b0, 8'hFF});
    tbl.push_back('{1'b0, 1'b1, 16'hFF48, 8'h00, 1'b1, 8'hFF});
    tbl.push_back('{1'b1, 1'b0, 16'hFF40, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 16'h8000, 8'hA5, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 16'hFE00, 8'h3C, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'h8000, 8'h00, 1'b1, 8'hA5});
    tbl.push_back('{1'b0, 1'b1, 16'hFE00, 8'h00, 1'b1, 8'h3C});
    tbl.push_back('{1'b1, 1'b0, 16'hFF44, 8'h55, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'hFF44, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'hFEA0, 8'h00, 1'b0, 8'hFF});
    tbl.push_back('{1'b1, 1'b0, 16'hFF42, 8'h12, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 16'hFF42, 8'h34, 1'b1, 8'h12});
    tbl.push_back('{1'b0, 1'b1, 16'hFF42, 8'h00, 1'b1, 8'h34});
    tbl.push_back('{1'b0, 1'b1, 16'hFF4B, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 1'b0, 16'hFF41, 8'hFF, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'hFF41, 8'h00, 1'b1, 8'hFC});
    tbl.push_back('{1'b1, 1'b0, 16'hFF45, 8'h05, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'hFF41, 8'h00, 1'b1, 8'hF8});
    tbl.push_back('{1'b1, 1'b0, 16'hFF41, 8'h40, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 16'hFF41, 8'h00, 1'b1, 8'hC0});

    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 8'hFF);
    check("reset_pix", pix, 2'd0);
    check("reset_pix_valid", pix_valid, 1'b0);
    check("reset_irqs", {irq_vblank, irq_stat}, 2'b00);
    reset_n = 1'b1;
    now = 0;

    // First cycle out of reset: coincidence flag still holds its reset value.
    bus_rd("stat_after_reset", 16'hFF41, 8'h82);

    foreach (tbl[i]) begin
      addr = tbl[i].a; wdata = tbl[i].d; we = tbl[i].we; re = tbl[i].re;
      #1;
      check($sformatf("hit[%0d]", i), hit, tbl[i].hit);
      tick();
      we = 1'b0; re = 1'b0;
      if (tbl[i].re) check($sformatf("rdata[%0d]", i), rdata, tbl[i].rd);
    end
    tick();
    check("rdata_hold", rdata, 8'hC0);
    check("lcd_off_blank", {hblank, vblank, pix_valid}, 3'b000);

    // LCD on: cycle 0 is line 0, dot 0.
    bus_wr(16'hFF40, 8'h91);
    now = 0;
    mon_en = 1'b1;
    run_to(100);           bus_rd("vram_rd_mode3", 16'h8000, 8'hFF);
    bus_wr(16'h8000, 8'h11);
    run_to(300);           bus_rd("vram_rd_mode0", 16'h8000, 8'hA5);
    run_to(LINE - 1);      bus_rd("ly_end_line0", 16'hFF44, 8'h00);
    run_to(LINE);          bus_rd("ly_line1", 16'hFF44, 8'h01);
    run_to(LINE + 10);     bus_rd("oam_rd_mode2", 16'hFE00, 8'hFF);
    run_to(LINE + 144);    bus_rd("oam_rd_mode3", 16'hFE00, 8'hFF);
    run_to(LINE + 300);    bus_rd("oam_rd_mode0", 16'hFE00, 8'h3C);
    run_to(5 * LINE + 300); bus_rd("stat_line5", 16'hFF41, 8'hC4);
    run_to(6 * LINE + 300); bus_rd("stat_line6", 16'hFF41, 8'hC0);
    run_to(144 * LINE + 10); bus_rd("stat_vblank", 16'hFF41, 8'hC1);
    run_to(MON_END + 2);
    check("frame_cycles_seen", cyc, MON_END);
    check("vblank_bad_cycles", bad_vb, 0);
    check("hblank_bad_cycles", bad_hb, 0);
    check("irq_vblank_bad_cycles", bad_iv, 0);
    check("irq_stat_bad_cycles", bad_is, 0);
    check("pix_valid_bad_cycles", bad_pv, 0);

    bus_wr(16'hFF40, 8'h00);
    for (int i = 0; i < 1024; i++) bus_wr(16'h9800 + 16'(i), 8'h00);
    set_rows(16'h8000, 8'hFF, 8'h00);
    pix_phase("solid", 8'h91, 8'h00, 8'hE4, 8'hFF, 8'h00);
    set_rows(16'h8000, 8'hFF, 8'h0F);
    pix_phase("split_scx0", 8'h91, 8'h00, 8'hE4, 8'hFF, 8'h0F);
    pix_phase("split_scx3", 8'h91, 8'h03, 8'hE4, 8'hFF, 8'h0F);
    pix_phase("bg_off", 8'h90, 8'h00, 8'h1B, 8'hFF, 8'h0F);
    set_rows(16'h9000, 8'h00, 8'hFF);
    pix_phase("signed_tiles", 8'h81, 8'h00, 8'hE4, 8'h00, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
